// File: rtl/instr_seq_ctrl_pkg.sv
// Shared definitions for the instruction fetch/issue sequencer: state encoding,
// IR field positions and the halt instruction (used when INSTR_SEQ_HALT_EN is defined).
package instr_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MWAIT = 3'd2,
        ST_INCPC = 3'd3,
        ST_ISSUE = 3'd4,
        ST_ACK   = 3'd5,
        ST_EXEC  = 3'd6,
        ST_HALT  = 3'd7
    } seq_state_t;

    localparam int OPCODE_HI = 15;
    localparam int OPCODE_LO = 13;
    localparam int OP_HI     = 12;
    localparam int OP_LO     = 11;

    // Wide enough for the largest legal memory latency (7).
    localparam int LAT_W = 3;

    localparam logic [15:0] HALT_INSTR = 16'hFFFF;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr == HALT_INSTR;
    endfunction

endpackage

// File: rtl/instr_seq_ctrl_pc_reg.sv
// Program counter register for the sequencer: synchronous reset to RESET_PC,
// parallel load, and modulo-2^ADDR_W increment.
module seq_pc_reg
    import instr_seq_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // Load takes priority over increment; the all-ones value wraps to zero silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Instruction fetch/issue sequencer above the datapath control FSM.
// Optional halt-on-16'hFFFF support is enabled by defining INSTR_SEQ_HALT_EN.
module instr_seq_ctrl
    import instr_seq_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0,
    parameter int MEM_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               w,
    output logic               s,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [2:0]         opcode,
    output logic [1:0]         op,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy
`ifdef INSTR_SEQ_HALT_EN
    ,
    output logic               halted
`endif
);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [LAT_W-1:0] lat_cnt;
    logic             pc_inc;

    seq_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (1'b0),
        .load_val ('0),
        .inc      (pc_inc),
        .pc       (pc)
    );

    assign mem_addr = pc;
    assign opcode   = ir[OPCODE_HI:OPCODE_LO];
    assign op       = ir[OP_HI:OP_LO];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latency counter counts down MEM_LAT-1..0 across MWAIT; IR captures on the zero cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt <= '0;
            ir      <= '0;
        end else begin
            if (state == ST_FETCH) begin
                lat_cnt <= LAT_W'(MEM_LAT - 1);
            end else if (state == ST_MWAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (state == ST_MWAIT && lat_cnt == '0) begin
                ir <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        s          = 1'b0;
        mem_rd     = 1'b0;
        busy       = 1'b1;
        pc_inc     = 1'b0;
`ifdef INSTR_SEQ_HALT_EN
        halted     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (run && w) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_rd     = 1'b1;
                state_next = ST_MWAIT;
            end
            ST_MWAIT: begin
                if (lat_cnt == '0) begin
                    state_next = ST_INCPC;
                end
            end
            ST_INCPC: begin
                pc_inc     = 1'b1;
                state_next = ST_ISSUE;
`ifdef INSTR_SEQ_HALT_EN
                if (is_halt(ir)) begin
                    state_next = ST_HALT;
                end
`endif
            end
            // Start is held until the datapath is seen in Wait, so it is accepted exactly once.
            ST_ISSUE: begin
                s = 1'b1;
                if (w) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!w) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w) begin
                    state_next = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT: begin
`ifdef INSTR_SEQ_HALT_EN
                halted = 1'b1;
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    a_single_read: assert property (@(posedge clk) disable iff (reset) mem_rd |=> !mem_rd);
    a_single_start: assert property (@(posedge clk) disable iff (reset) (s && w) |=> !s);

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: two instances (MEM_LAT=1/RESET_PC=0 and
// MEM_LAT=3/RESET_PC=511) against a timeline model; honours INSTR_SEQ_HALT_EN.
module tb_instr_seq_ctrl;

   localparam int NCYC = 3000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int totalChecks = 0;
   int totalFails = 0;

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int ML  = (g == 0) ? 1 : 3;
      localparam int RPC = (g == 0) ? 0 : 511;
`ifdef INSTR_SEQ_HALT_EN
      localparam bit HALT_EN = 1'b1;
`else
      localparam bit HALT_EN = 1'b0;
`endif

      logic        reset = 1'b1;
      logic        run = 1'b0;
      logic        w = 1'b1;
      logic        s;
      logic        mem_rd;
      logic [8:0]  mem_addr;
      logic [15:0] mem_rdata = 16'h0;
      logic [15:0] ir;
      logic [2:0]  opcode;
      logic [1:0]  op;
      logic [8:0]  pc;
      logic        busy;
`ifdef INSTR_SEQ_HALT_EN
      logic        halted;
`endif

      instr_seq_ctrl #(
         .ADDR_W   (9),
         .INSTR_W  (16),
         .RESET_PC (RPC),
         .MEM_LAT  (ML)
      ) dut (
         .clk       (clk),
         .reset     (reset),
         .run       (run),
         .w         (w),
         .s         (s),
         .mem_rd    (mem_rd),
         .mem_addr  (mem_addr),
         .mem_rdata (mem_rdata),
         .ir        (ir),
         .opcode    (opcode),
         .op        (op),
         .pc        (pc),
         .busy      (busy)
`ifdef INSTR_SEQ_HALT_EN
         ,
         .halted    (halted)
`endif
      );

      int  nv = 0;
      int  nf = 0;
      bit  done = 1'b0;

      logic [15:0] mem [512];

      // Model: m_t counts cycles since the fetch cycle (-1 = idle), then handshake flags.
      int          m_t = -1;
      bit          m_started = 1'b0;
      bit          m_low_seen = 1'b0;
      bit          m_halted = 1'b0;
      logic [8:0]  m_pc = 9'(RPC);
      logic [15:0] m_ir = 16'h0;

      // Environment state: memory read pipe and datapath busy time.
      bit          rd_pending = 1'b0;
      int          rd_k = 0;
      logic [8:0]  rd_a = 9'h0;
      int          dp_busy = 0;
      int          halt_cnt = 0;
      int          halt_activity = 0;
      bit          exec_reset_done = 1'b0;
      int          exec_reset_k = -10;

      // Compares one observed value against its expectation and records the outcome.
      task automatic checkOutput(input string name, input int k,
                                 input logic [31:0] act, input logic [31:0] exp);
         nv++;
         totalChecks++;
         if (act !== exp) begin
            nf++;
            totalFails++;
            $display("[TB] FAIL inst%0d %s cycle %0d: actual %0h required %0h",
                     g, name, k, act, exp);
         end
      endtask

      // Drives reset, run, w and mem_rdata for cycle k.
      task automatic applyStimulus(input int k);
         int lc;
         lc    = k - 3;
         reset = (k < 3);
         if (lc > 12) begin
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
            if (halt_cnt >= 25) begin
               checkOutput("halt_quiet", k, 32'(halt_activity), 32'd0);
               reset         = 1'b1;
               halt_cnt      = 0;
               halt_activity = 0;
               mem[2]        = 16'h1234;
            end
         end
         if (dp_busy > 0) begin
            w = 1'b0;
            dp_busy--;
         end else if (lc <= 12) begin
            w = 1'b1;
         end else begin
            w = ($urandom_range(0, 7) != 0);
         end
         if (lc > 12 && !exec_reset_done && m_started && m_low_seen && !w) begin
            reset           = 1'b1;
            exec_reset_done = 1'b1;
            exec_reset_k    = k;
         end
         if (lc <= 12) begin
            run = 1'b1;
         end else if ($urandom_range(0, 14) == 0) begin
            run = ~run;
         end
         if (rd_pending && k == rd_k + ML) begin
            mem_rdata = mem[rd_a];
         end else begin
            mem_rdata = (rd_pending ? mem[rd_a] : 16'h0) ^ (16'($urandom) | 16'h0001);
         end
      endtask

      // Compares DUT outputs against the model and the directed test-plan values.
      task automatic compareCycle(input int k);
         int lc;
         lc = k - 3;
         checkOutput("mem_rd", k, 32'(mem_rd), 32'(m_t == 0 && !m_halted));
         checkOutput("s", k, 32'(s), 32'(!m_halted && m_t == ML + 2 && !m_started));
         checkOutput("busy", k, 32'(busy), 32'(m_halted || m_t >= 0));
         checkOutput("pc", k, 32'(pc), 32'(m_pc));
         checkOutput("mem_addr", k, 32'(mem_addr), 32'(m_pc));
         checkOutput("ir", k, 32'(ir), 32'(m_ir));
         checkOutput("opcode", k, 32'(opcode), 32'(m_ir[15:13]));
         checkOutput("op", k, 32'(op), 32'(m_ir[12:11]));
`ifdef INSTR_SEQ_HALT_EN
         checkOutput("halted", k, 32'(halted), 32'(m_halted));
`endif
         if (k == exec_reset_k + 1) begin
            checkOutput("exec_rst_busy", k, 32'(busy), 32'd0);
            checkOutput("exec_rst_pc", k, 32'(pc), 32'(RPC));
            checkOutput("exec_rst_ir", k, 32'(ir), 32'd0);
            checkOutput("exec_rst_s", k, 32'(s), 32'd0);
         end
         if (g == 0) begin
            case (lc)
               1: begin
                  checkOutput("lit_mem_rd", k, 32'(mem_rd), 32'd1);
                  checkOutput("lit_addr0", k, 32'(mem_addr), 32'h000);
               end
               3: begin
                  checkOutput("lit_ir", k, 32'(ir), 32'hD0A5);
                  checkOutput("lit_opcode", k, 32'(opcode), 32'h6);
                  checkOutput("lit_op", k, 32'(op), 32'h2);
               end
               4: begin
                  checkOutput("lit_pc", k, 32'(pc), 32'h001);
                  checkOutput("lit_s", k, 32'(s), 32'd1);
               end
               9: begin
                  checkOutput("lit_mem_rd2", k, 32'(mem_rd), 32'd1);
                  checkOutput("lit_addr1", k, 32'(mem_addr), 32'h001);
               end
               default: ;
            endcase
         end else begin
            case (lc)
               1: begin
                  checkOutput("lit_mem_rd", k, 32'(mem_rd), 32'd1);
                  checkOutput("lit_addr1ff", k, 32'(mem_addr), 32'h1FF);
               end
               4: checkOutput("lit_no_garbage", k, 32'(ir), 32'h0000);
               5: checkOutput("lit_ir", k, 32'(ir), 32'h3C5A);
               6: begin
                  checkOutput("lit_s", k, 32'(s), 32'd1);
                  checkOutput("lit_pc_wrap", k, 32'(pc), 32'h000);
                  checkOutput("lit_addr_wrap", k, 32'(mem_addr), 32'h000);
               end
               default: ;
            endcase
         end
      endtask

      // Tracks memory reads, datapath start acceptance and activity while halted.
      task automatic observeEnv(input int k);
         int lc;
         lc = k - 3;
         if (mem_rd === 1'b1) begin
            rd_pending = 1'b1;
            rd_k       = k;
            rd_a       = mem_addr;
         end
         if (s === 1'b1 && w) begin
            dp_busy = (lc <= 12) ? 3 : int'($urandom_range(1, 5));
         end
         if (m_halted) begin
            halt_cnt++;
            if (s !== 1'b0 || mem_rd !== 1'b0) halt_activity++;
         end
      endtask

      // Advance the model by one clock using this cycle's inputs.
      task automatic updateModel();
         if (reset) begin
            m_t        = -1;
            m_started  = 1'b0;
            m_low_seen = 1'b0;
            m_halted   = 1'b0;
            m_pc       = 9'(RPC);
            m_ir       = 16'h0;
         end else if (m_halted) begin
            m_halted = 1'b1;
         end else if (m_t < 0) begin
            if (run && w) m_t = 0;
         end else if (m_t <= ML) begin
            if (m_t == ML) m_ir = mem[m_pc];
            m_t++;
         end else if (m_t == ML + 1) begin
            m_pc = m_pc + 9'd1;
            if (HALT_EN && m_ir == 16'hFFFF) m_halted = 1'b1;
            else m_t++;
         end else if (!m_started) begin
            if (w) m_started = 1'b1;
         end else if (!m_low_seen) begin
            if (!w) m_low_seen = 1'b1;
         end else if (w) begin
            m_started  = 1'b0;
            m_low_seen = 1'b0;
            m_t        = run ? 0 : -1;
         end
      endtask

      // Per-instance main loop: stimulus after each posedge, compare at negedge.
      initial begin
         for (int a = 0; a < 512; a++) mem[a] = 16'($urandom);
         if (g == 0) begin
            mem[0] = 16'hD0A5;
            mem[2] = 16'hFFFF;
         end else begin
            mem[511] = 16'h3C5A;
         end
         for (int k = 0; k < NCYC; k++) begin
            @(posedge clk);
            #1;
            applyStimulus(k);
            @(negedge clk);
            if (k >= 1) compareCycle(k);
            observeEnv(k);
            updateModel();
         end
         done = 1'b1;
      end
   end

   // Final summary once both instances have finished.
   initial begin
      wait (inst[0].done && inst[1].done);
      $display("[TB] == %0d vectors applied, %0d miscompares ==",
               totalChecks, totalFails);
      $finish;
   end

   // Watchdog in case the bench hangs.
   initial begin
      #(NCYC * 10 * 4);
      $display("[TB] FAIL watchdog: bench did not complete, actual running required done");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
